fifo_read_streamer: RTL and testbench

Read-side consumer for the async FIFO. It sits in the rd_clk domain, drives the FIFO's rd_en from its empty flag, and captures the registered FIFO Data_out one cycle later. It presents the words downstream as a valid/ready stream through a small elastic buffer, so downstream back-pressure never drops or duplicates a word. It also keeps a running count of delivered words.

---
 rtl/fifo_read_streamer_pkg.sv | 32 +++
 rtl/read_elastic_buffer.sv | 85 ++++++++
 rtl/fifo_read_streamer.sv | 82 ++++++++
 tb/tb_fifo_read_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_streamer_pkg
//  Description : Shared constants and helpers for the FIFO read streamer:
//                elastic-buffer depth limits, the default word width shared
//                with the async FIFO top, and a ceiling-log2 helper used to
//                size pointers and occupancy counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_read_streamer_pkg;

    // Legal elastic-buffer depth range.
    localparam int c_BUF_DEPTH_MIN     = 2;
    localparam int c_BUF_DEPTH_MAX     = 8;

    // Word width of the async FIFO this block consumes from.
    localparam int c_DATA_BITS_DEFAULT = 8;

    // Ceiling log2 for small positive values (0 for value <= 1).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : read_elastic_buffer
//  Description : Circular elastic buffer between the FIFO capture register
//                and the downstream valid/ready stream. Holds up to
//                BUF_DEPTH words; head entry is presented while occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_elastic_buffer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS_DEFAULT,
    parameter int BUF_DEPTH = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  logic [DATA_BITS-1:0]                 push_data_i,
    input  logic                                 pop_i,
    output logic                                 valid_o,
    output logic [DATA_BITS-1:0]                 data_o,
    output logic [clog2_f(BUF_DEPTH + 1)-1:0]    occ_o
);

    localparam int PTR_W = clog2_f(BUF_DEPTH);
    localparam int OCC_W = clog2_f(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_BITS-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q,  occ_d;
    logic                 w_pop;

    // A pop with nothing buffered is ignored so occupancy can never underflow.
    assign w_pop = pop_i && (occ_q != '0);

    // Next pointers (wrapping at the last entry) and occupancy.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) begin
            tail_d = (tail_q == c_LAST_PTR) ? '0 : tail_q + 1'b1;
        end
        if (w_pop) begin
            head_d = (head_q == c_LAST_PTR) ? '0 : head_q + 1'b1;
        end
        case ({push_i, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage written at the tail; cleared on reset so the idle output reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = mem_q[head_q];
    assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_streamer
//  Description : Read-side consumer of the async FIFO. Issues rd_en from the
//                registered empty flag when a buffer slot is free, captures
//                the registered FIFO output one cycle later, and streams the
//                words out as valid/ready. Counts completed handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_streamer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS_DEFAULT,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_BITS  = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 enable,
    input  logic                 empty,
    output logic                 rd_en,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic [CNT_BITS-1:0]  word_count,
    output logic                 idle
);

    localparam int OCC_W = clog2_f(BUF_DEPTH + 1);
    localparam logic [OCC_W:0] c_DEPTH = (OCC_W + 1)'(BUF_DEPTH);

    logic                run_q;
    logic                inflight_q;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [OCC_W-1:0]    w_occ;
    logic [OCC_W:0]      w_reserved;
    logic                w_pop;

    // Slots already spoken for: buffered words plus the word on its way in.
    // Reserving at issue time is what makes a capture overflow impossible.
    assign w_reserved = {1'b0, w_occ} + {{OCC_W{1'b0}}, inflight_q};

    // Issue depends only on registered state and FIFO flags, never on m_ready.
    // run_q keeps rd_en low while reset is asserted.
    assign rd_en = run_q && enable && !empty && (w_reserved < c_DEPTH);

    assign w_pop   = m_valid && m_ready;
    assign count_d = w_pop ? count_q + 1'b1 : count_q;

    // Read-issue bookkeeping and the delivered-word counter.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= rd_en;
            count_q    <= count_d;
        end
    end

    read_elastic_buffer #(
        .DATA_BITS (DATA_BITS),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i       (rd_clk),
        .rst_ni      (rd_rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_data),
        .pop_i       (w_pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .occ_o       (w_occ)
    );

    assign word_count = count_q;
    assign idle       = (w_occ == '0) && !inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_streamer
//  Description : Self-checking bench for fifo_read_streamer. A queue-based
//                FIFO model feeds the DUT; a scoreboard of pushed words is
//                compared against words seen on the valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_streamer;

    localparam int TB_DATA  = 8;
    localparam int TB_DEPTH = 3;
    localparam int TB_CNT   = 4;

    logic                rd_clk;
    logic                rd_rst;
    logic                enable;
    logic                empty;
    logic                rd_en;
    logic [TB_DATA-1:0]  fifo_data;
    logic                m_valid;
    logic                m_ready;
    logic [TB_DATA-1:0]  m_data;
    logic [TB_CNT-1:0]   word_count;
    logic                idle;

    fifo_read_streamer #(
        .DATA_BITS (TB_DATA),
        .BUF_DEPTH (TB_DEPTH),
        .CNT_BITS  (TB_CNT)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .enable     (enable),
        .empty      (empty),
        .rd_en      (rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .word_count (word_count),
        .idle       (idle)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [TB_DATA-1:0] pend_q[$];
    logic [TB_DATA-1:0] fifo_q[$];
    logic [TB_DATA-1:0] exp_q[$];
    logic [TB_DATA-1:0] got_q[$];
    int                 got_t[$];
    int                 exp_total = 0;
    int                 rd_cnt    = 0;
    int                 cyc       = 0;
    bit                 rd_when_empty = 0;

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // FIFO model: registered Data_out and registered empty flag.
    initial begin
        empty     = 1'b1;
        fifo_data = '0;
    end
    always @(posedge rd_clk) begin
        if (rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        empty <= (fifo_q.size() == 0);
    end

    // Output observer: records delivered words and read strobes.
    always @(negedge rd_clk) begin
        cyc++;
        if (rd_rst) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_t.push_back(cyc);
            end
            if (rd_en) rd_cnt++;
            if (rd_en && empty) rd_when_empty = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #2;
        end
    endtask

    task automatic push_word(input logic [TB_DATA-1:0] w);
        pend_q.push_back(w);
        exp_q.push_back(w);
        exp_total++;
    endtask

    task automatic clear_sb();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_got(input int n, input int budget, output bit timed_out);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        timed_out = (got_q.size() < n);
    endtask

    task automatic test_reset();
        rd_rst  = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(3);
        n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h want 00", m_data); else n_pass++;
        n_checks++; if (word_count !== 4'd0) $display("FAIL reset_word_count: got %0d want 0", word_count); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else n_pass++;
        rd_rst    = 1'b1;
        exp_total = 0;
        tick(2);
    endtask

    task automatic test_basic_latency();
        bit found;
        clear_sb();
        enable  = 1'b1;
        m_ready = 1'b1;
        push_word(8'hA5);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge rd_clk);
            if (rd_en) found = 1;
        end
        n_checks++; if (!found) $display("FAIL latency_rd_en_timeout: got no rd_en want rd_en within 20 cycles"); else n_pass++;
        @(negedge rd_clk);
        n_checks++; if (m_valid !== 1'b0) $display("FAIL latency_valid_n1: got %b want 0", m_valid); else n_pass++;
        @(negedge rd_clk);
        n_checks++; if (m_valid !== 1'b1) $display("FAIL latency_valid_n2: got %b want 1", m_valid); else n_pass++;
        n_checks++; if (m_data !== 8'hA5) $display("FAIL latency_data_n2: got %h want a5", m_data); else n_pass++;
        @(negedge rd_clk);
        n_checks++; if (word_count !== exp_total[TB_CNT-1:0]) $display("FAIL latency_count_n3: got %0d want %0d", word_count, exp_total[TB_CNT-1:0]); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL latency_idle_n3: got %b want 1", idle); else n_pass++;
        tick(2);
    endtask

    task automatic test_streaming();
        bit to;
        clear_sb();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(TB_DATA'(i));
        wait_got(16, 80, to);
        tick(1);
        n_checks++; if (to) $display("FAIL stream_timeout: got %0d words want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16 && !to; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        if (!to) begin
            n_checks++; if (got_t[15] - got_t[0] != 15) $display("FAIL stream_rate: got %0d cycles want 15", got_t[15] - got_t[0]); else n_pass++;
        end
        n_checks++; if (word_count !== exp_total[TB_CNT-1:0]) $display("FAIL stream_count: got %0d want %0d", word_count, exp_total[TB_CNT-1:0]); else n_pass++;
        n_checks++; if (rd_when_empty) $display("FAIL stream_rd_en_empty: got rd_en while empty want never"); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL stream_idle: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        int base;
        clear_sb();
        m_ready = 1'b0;
        enable  = 1'b1;
        base    = rd_cnt;
        for (int i = 0; i < 12; i++) push_word(TB_DATA'($urandom));
        tick(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk);
            if (m_valid) begin
                n_checks++; if (m_data !== exp_q[0]) $display("FAIL bp_hold_c%0d: got %h want %h", c, m_data, exp_q[0]); else n_pass++;
            end
        end
        n_checks++; if (rd_cnt - base != TB_DEPTH) $display("FAIL bp_reads: got %0d want %0d", rd_cnt - base, TB_DEPTH); else n_pass++;
        n_checks++; if (rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b want 0", rd_en); else n_pass++;
        n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", m_valid); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL bp_idle: got %b want 0", idle); else n_pass++;
        tick(1);
        m_ready = 1'b1;
        wait_got(12, 80, to);
        tick(1);
        n_checks++; if (to || got_q.size() != 12) $display("FAIL bp_drain: got %0d words want 12", got_q.size()); else n_pass++;
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (word_count !== exp_total[TB_CNT-1:0]) $display("FAIL bp_count: got %0d want %0d", word_count, exp_total[TB_CNT-1:0]); else n_pass++;
    endtask

    task automatic test_enable_toggle();
        bit to;
        bit found;
        int base;
        clear_sb();
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(TB_DATA'($urandom));
        tick(3);
        base   = rd_cnt;
        enable = 1'b1;
        found  = 0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge rd_clk);
            if (rd_en) found = 1;
        end
        n_checks++; if (!found) $display("FAIL en_first_read_timeout: got no rd_en want rd_en"); else n_pass++;
        @(posedge rd_clk);
        #2;
        enable = 1'b0;
        tick(8);
        n_checks++; if (rd_cnt - base != 1) $display("FAIL en_reads_while_off: got %0d want 1", rd_cnt - base); else n_pass++;
        n_checks++; if (got_q.size() != 1) $display("FAIL en_inflight_delivered: got %0d words want 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL en_inflight_word: got %h want %h", got_q[0], exp_q[0]); else n_pass++;
        end
        n_checks++; if (idle !== 1'b1) $display("FAIL en_idle_off: got %b want 1", idle); else n_pass++;
        enable = 1'b1;
        wait_got(8, 60, to);
        tick(1);
        n_checks++; if (to || got_q.size() != 8) $display("FAIL en_resume: got %0d words want 8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL en_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        if (got_q.size() == 8) begin
            n_checks++; if (got_t[7] - got_t[1] != 6) $display("FAIL en_resume_rate: got %0d cycles want 6", got_t[7] - got_t[1]); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit to;
        int target;
        clear_sb();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) push_word(TB_DATA'($urandom));
            m_ready = ($urandom_range(0, 2) != 0);
            enable  = ($urandom_range(0, 5) != 0);
            tick(1);
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        target  = exp_q.size();
        wait_got(target, 400, to);
        tick(2);
        n_checks++; if (to || got_q.size() != target) $display("FAIL rand_drain: got %0d words want %0d", got_q.size(), target); else n_pass++;
        for (int i = 0; i < target && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (word_count !== exp_total[TB_CNT-1:0]) $display("FAIL rand_count: got %0d want %0d", word_count, exp_total[TB_CNT-1:0]); else n_pass++;
        n_checks++; if (rd_when_empty) $display("FAIL rand_rd_en_empty: got rd_en while empty want never"); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rand_idle: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_sb();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(TB_DATA'($urandom_range(1, 255)));
        tick(5);
        rd_rst = 1'b0;
        #1;
        n_checks++; if (rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b want 0", rd_en); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (m_data !== 8'h00) $display("FAIL midrst_m_data: got %h want 00", m_data); else n_pass++;
        n_checks++; if (word_count !== 4'd0) $display("FAIL midrst_count: got %0d want 0", word_count); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL midrst_idle: got %b want 1", idle); else n_pass++;
        fifo_q.delete();
        pend_q.delete();
        clear_sb();
        exp_total = 0;
        tick(2);
        rd_rst  = 1'b1;
        m_ready = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) push_word(TB_DATA'($urandom));
        wait_got(4, 40, to);
        tick(3);
        n_checks++; if (got_q.size() != 4) $display("FAIL midrst_after_words: got %0d want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL midrst_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_counter_wrap();
        bit to;
        rd_rst = 1'b0;
        tick(2);
        rd_rst    = 1'b1;
        exp_total = 0;
        clear_sb();
        enable  = 1'b1;
        m_ready = 1'b1;
        tick(1);
        for (int i = 0; i < 17; i++) push_word(TB_DATA'($urandom));
        wait_got(17, 80, to);
        tick(2);
        n_checks++; if (to) $display("FAIL wrap_timeout: got %0d words want 17", got_q.size()); else n_pass++;
        n_checks++; if (word_count !== 4'd1) $display("FAIL wrap_count: got %0d want 1", word_count); else n_pass++;
    endtask

    initial begin
        rd_rst  = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_basic_latency();
        test_streaming();
        test_backpressure();
        test_enable_toggle();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
